regfile_sequencer: RTL and testbench
====================================

Name: regfile_sequencer

Overview:
Command-driven initiator for the 2-entry, 8-bit register file. It accepts host commands (write, read, add, swap) over a valid/ready handshake and drives the register file's port set: one write port with active-low write_enable, and two combinational read ports. It returns exactly one response per command over a second valid/ready handshake. It sits between the datapath control logic and the register file, and is the only master of the register file's write port.

Parameters:
DATA_WIDTH, 8, width of register contents, cmd_data, rsp_data and write_data; the register file is 8 bits, so only 8 is supported in this design.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  00 WRITE, 01 READ, 10 ADD, 11 SWAP
cmd_reg  input  1  target register index
cmd_data  input  DATA_WIDTH  write data (WRITE only)
rsp_valid  output  1  response present
rsp_ready  input  1  host accepts response
rsp_data  output  DATA_WIDTH  response data
rsp_carry  output  1  ADD carry-out; 0 for all other ops
busy  output  1  high in any state other than IDLE
read_register1  output  1  register file read port 1 index
read_register2  output  1  register file read port 2 index
write_enable  output  1  register file write strobe, active-low
write_register  output  1  register file write index
write_data  output  DATA_WIDTH  register file write data
read_data1  input  DATA_WIDTH  register file read port 1 data
read_data2  input  DATA_WIDTH  register file read port 2 data

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-high.
- Reset values:
  - state IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_carry=0; busy=0.
  - write_enable=1 (inactive); write_register=0; write_data=0; read_register1=0; read_register2=1.
- States: IDLE, EXEC, SWAP2, RESP.
- Port-side outputs (read/write indices, write_enable, write_data) are combinational from state plus latched command. Outside EXEC/SWAP2 they hold the reset values above.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready at a rising edge: latch op, reg and data into internal registers; go to EXEC.
  - cmd_ready=0 in every other state; cmd_* are ignored there.
- EXEC (exactly one cycle):
  - WRITE: write_enable=0, write_register=reg, write_data=data. Capture rsp_data=data, rsp_carry=0. Go to RESP.
  - READ: read_register1=reg, write_enable=1. Capture rsp_data=read_data1, rsp_carry=0. Go to RESP.
  - ADD: read_register1=0, read_register2=1. Compute 9-bit sum = read_data1 + read_data2. Drive write_enable=0, write_register=reg, write_data=sum[7:0]. Capture rsp_data=sum[7:0], rsp_carry=sum[8]. Go to RESP.
  - SWAP: read_register1=0, read_register2=1. Drive write_enable=0, write_register=0, write_data=read_data2. Save read_data1 into a temp register. Go to SWAP2.
- SWAP2 (one cycle): write_enable=0, write_register=1, write_data=temp. Capture rsp_data=temp (old r0), rsp_carry=0. Go to RESP.
- RESP:
  - rsp_valid=1. rsp_data and rsp_carry stay stable until handshake.
  - On rsp_ready: go to IDLE; rsp_valid drops on the next cycle.
  - rsp_ready while rsp_valid=0 has no effect.
- Latency, counting from the accept edge N:
  - rsp_valid is high after edge N+1 for WRITE/READ/ADD.
  - rsp_valid is high after edge N+2 for SWAP.
  - Back-to-back throughput is one command per 3 cycles (4 for SWAP) with rsp_ready held high.
- write_enable is low for exactly 1 cycle per WRITE/ADD command and 2 consecutive cycles per SWAP; it is never low in IDLE or RESP.
- ADD wrap-around: 8'hFF+8'h01 gives rsp_data=8'h00, rsp_carry=1, and writes 8'h00.
- ADD with reg=0 or reg=1 overwrites that operand. Reads complete in the same cycle, before the write edge, so the result is well defined.
- SWAP with r0==r1: writes are still issued; contents are unchanged.
- Reset mid-operation (EXEC, SWAP2 or RESP): immediate return to IDLE; write_enable goes to 1 asynchronously; any pending response is discarded.
  - A SWAP interrupted after EXEC leaves r0 updated and r1 stale. This is acceptable; the host re-initialises after reset.

Test Plan:
- Reset, then WRITE reg0=8'hA5 and WRITE reg1=8'h3C:
  - write_enable low 1 cycle each with write_register 0 then 1;
  - responses 8'hA5 and 8'h3C, carry 0.
- READ reg1 after the above -> read_register1=1 in EXEC; rsp_data=8'h3C; write_enable stays 1 throughout.
- r0=8'hFF, r1=8'h01, ADD reg1 -> write_data=8'h00 to reg1; rsp_data=8'h00, rsp_carry=1; a subsequent READ reg1 returns 8'h00.
- r0=8'h12, r1=8'h34, SWAP:
  - two consecutive write cycles: (reg0, 8'h34) then (reg1, 8'h12);
  - rsp_data=8'h12;
  - subsequent READs return r0=8'h34, r1=8'h12.
- Response backpressure: hold rsp_ready=0 for 5 cycles after a READ -> rsp_valid and rsp_data stable, cmd_ready=0, a new cmd_valid is not accepted; release -> exactly one handshake, then cmd_ready=1.
- Assert reset during the SWAP2 cycle -> write_enable=1 immediately; rsp_valid=0, cmd_ready=1, busy=0; no response is ever produced for that command.

Source files
------------

// File: rtl/regfile_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_sequencer
//
// Command-driven initiator for a 2-entry register file. Host commands
// (WRITE, READ, ADD, SWAP) arrive over a valid/ready handshake. Each command
// is run against the register file's write port (active-low write_enable)
// and its two combinational read ports. Exactly one response goes back per
// command over a second valid/ready handshake. This block is the only master
// of the register file's write port.
//
// Ports
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_op, cmd_reg, cmd_data payload
//   rsp_valid/rsp_ready  response handshake; rsp_data, rsp_carry payload
//   busy                 high whenever the sequencer is not in IDLE
//   read_register1/2     register file read indices
//   read_data1/2         register file read data (combinational)
//   write_enable         register file write strobe, active-low
//   write_register       register file write index
//   write_data           register file write data
// ---------------------------------------------------------------------------
module regfile_sequencer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  // host command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic                  cmd_reg,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  // host response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_carry,
  output logic                  busy,
  // register file port set
  output logic                  read_register1,
  output logic                  read_register2,
  output logic                  write_enable,
  output logic                  write_register,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data1,
  input  logic [DATA_WIDTH-1:0] read_data2
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SWAP2 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_ADD   = 2'b10,
    OP_SWAP  = 2'b11
  } op_e;

  state_e                state_q,     state_d;
  op_e                   op_q,        op_d;
  logic                  reg_q,       reg_d;
  logic [DATA_WIDTH-1:0] data_q,      data_d;
  logic [DATA_WIDTH-1:0] temp_q,      temp_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic                  rsp_carry_q, rsp_carry_d;

  // One extra bit holds the ADD carry-out.
  logic [DATA_WIDTH:0]   sum;

  assign sum = {1'b0, read_data1} + {1'b0, read_data2};

  // NOTE: every register has an async reset, including the command and temp
  // holding registers, so the response path never exposes X after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_WRITE;
      reg_q       <= 1'b0;
      data_q      <= '0;
      temp_q      <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so that every register samples
      // the pre-edge values of the others, whatever the statement order.
      state_q     <= state_d;
      op_q        <= op_d;
      reg_q       <= reg_d;
      data_q      <= data_d;
      temp_q      <= temp_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first. A path that
    // leaves one unassigned would infer a latch.
    state_d        = state_q;
    op_d           = op_q;
    reg_d          = reg_q;
    data_d         = data_q;
    temp_d         = temp_q;
    rsp_data_d     = rsp_data_q;
    rsp_carry_d    = rsp_carry_q;
    // The port-side outputs rest at their idle values outside EXEC/SWAP2.
    read_register1 = 1'b0;
    read_register2 = 1'b1;
    write_enable   = 1'b1;
    write_register = 1'b0;
    write_data     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          reg_d   = cmd_reg;
          data_d  = cmd_data;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        unique case (op_q)
          OP_WRITE: begin
            write_enable   = 1'b0;
            write_register = reg_q;
            write_data     = data_q;
            rsp_data_d     = data_q;
            rsp_carry_d    = 1'b0;
            state_d        = ST_RESP;
          end
          OP_READ: begin
            read_register1 = reg_q;
            rsp_data_d     = read_data1;
            rsp_carry_d    = 1'b0;
            state_d        = ST_RESP;
          end
          OP_ADD: begin
            // The operands come from r0 and r1 through the default read
            // indices. The reads settle before the write edge, so writing
            // back over an operand is well defined.
            write_enable   = 1'b0;
            write_register = reg_q;
            write_data     = sum[DATA_WIDTH-1:0];
            rsp_data_d     = sum[DATA_WIDTH-1:0];
            rsp_carry_d    = sum[DATA_WIDTH];
            state_d        = ST_RESP;
          end
          OP_SWAP: begin
            // First half: r0 <- r1. Old r0 is parked in temp for SWAP2.
            write_enable   = 1'b0;
            write_register = 1'b0;
            write_data     = read_data2;
            temp_d         = read_data1;
            state_d        = ST_SWAP2;
          end
          default: state_d = ST_IDLE;
        endcase
      end

      ST_SWAP2: begin
        write_enable   = 1'b0;
        write_register = 1'b1;
        write_data     = temp_q;
        rsp_data_d     = temp_q;
        rsp_carry_d    = 1'b0;
        state_d        = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // All handshake outputs are decoded from the state register. Reset
  // therefore forces them to their idle values without waiting for a clock.
  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// ---------------------------------------------------------------------------
// tb_regfile_sequencer
//
// Directed bench for regfile_sequencer. A behavioural 2-entry register file
// is attached to the sequencer's port set. Hand-computed expectations cover
// the reset state, each command, ADD carry wrap-around, SWAP sequencing,
// response backpressure and reset during SWAP2.
// ---------------------------------------------------------------------------
module tb_regfile_sequencer;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_reg;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       busy;
  logic       read_register1;
  logic       read_register2;
  logic       write_enable;
  logic       write_register;
  logic [7:0] write_data;
  logic [7:0] read_data1;
  logic [7:0] read_data2;

  int n_total = 0;
  int n_pass  = 0;

  // Event counters, updated only while reset is low.
  int we_low_cnt = 0;
  int hs_cnt     = 0;
  int rv_cnt     = 0;

  logic [7:0] rf [2];

  regfile_sequencer #(.DATA_WIDTH(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_reg        (cmd_reg),
    .cmd_data       (cmd_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_carry      (rsp_carry),
    .busy           (busy),
    .read_register1 (read_register1),
    .read_register2 (read_register2),
    .write_enable   (write_enable),
    .write_register (write_register),
    .write_data     (write_data),
    .read_data1     (read_data1),
    .read_data2     (read_data2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file model: writes on the clock edge, reads are combinational.
  always @(posedge clock) begin
    if (!write_enable) rf[write_register] <= write_data;
  end
  assign read_data1 = rf[read_register1];
  assign read_data2 = rf[read_register2];

  always @(posedge clock) begin
    if (!reset) begin
      if (!write_enable)          we_low_cnt <= we_low_cnt + 1;
      if (rsp_valid && rsp_ready) hs_cnt     <= hs_cnt + 1;
      if (rsp_valid)              rv_cnt     <= rv_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge while in IDLE. Presents the command for one edge and
  // returns at the following negedge, where the sequencer is in EXEC.
  task automatic send(input logic [1:0] op, input logic r, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_reg   = r;
    cmd_data  = d;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  // Called at the negedge of the last EXEC/SWAP2 cycle. The response must be
  // valid at the very next negedge. When rsp_ready is high, the handshake is
  // followed through and the task returns in IDLE.
  task automatic expect_resp(input string tag, input logic [7:0] d,
                             input logic c);
    int waited = 0;
    @(negedge clock);
    while (!rsp_valid && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    check({tag, "_latency"}, 16'(waited), 16'd0);
    check({tag, "_rsp_valid"}, 16'(rsp_valid), 16'd1);
    check({tag, "_rsp_data"}, 16'(rsp_data), 16'(d));
    check({tag, "_rsp_carry"}, 16'(rsp_carry), 16'(c));
    if (rsp_ready) begin
      @(negedge clock);
      check({tag, "_idle_cmd_ready"}, 16'(cmd_ready), 16'd1);
      check({tag, "_idle_rsp_valid"}, 16'(rsp_valid), 16'd0);
    end
  endtask

  // Runs a complete WRITE at a negedge in IDLE.
  task automatic do_write(input logic r, input logic [7:0] d);
    send(OP_WRITE, r, d);
    expect_resp("wr", d, 1'b0);
  endtask

  task automatic do_read(input string tag, input logic r, input logic [7:0] d);
    send(OP_READ, r, d);
    check({tag, "_rd_idx"}, 16'(read_register1), 16'(r));
    check({tag, "_rd_we"}, 16'(write_enable), 16'd1);
    expect_resp(tag, d, 1'b0);
  endtask

  initial begin
    int we0;
    int hs0;
    int rv0;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_reg   = 1'b0;
    cmd_data  = 8'h00;
    rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_cmd_ready", 16'(cmd_ready), 16'd1);
    check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    check("rst_rsp_data", 16'(rsp_data), 16'h0);
    check("rst_rsp_carry", 16'(rsp_carry), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_we", 16'(write_enable), 16'd1);
    check("rst_wreg", 16'(write_register), 16'd0);
    check("rst_wdata", 16'(write_data), 16'h0);
    check("rst_rr1", 16'(read_register1), 16'd0);
    check("rst_rr2", 16'(read_register2), 16'd1);
    reset = 1'b0;
    @(negedge clock);

    // WRITE r0=A5, then WRITE r1=3C
    we0 = we_low_cnt;
    send(OP_WRITE, 1'b0, 8'hA5);
    check("w0_we", 16'(write_enable), 16'd0);
    check("w0_wreg", 16'(write_register), 16'd0);
    check("w0_wdata", 16'(write_data), 16'h00A5);
    check("w0_busy", 16'(busy), 16'd1);
    check("w0_cmd_ready", 16'(cmd_ready), 16'd0);
    expect_resp("w0", 8'hA5, 1'b0);
    check("w0_we_cycles", 16'(we_low_cnt - we0), 16'd1);
    check("w0_rf0", 16'(rf[0]), 16'h00A5);

    we0 = we_low_cnt;
    send(OP_WRITE, 1'b1, 8'h3C);
    check("w1_we", 16'(write_enable), 16'd0);
    check("w1_wreg", 16'(write_register), 16'd1);
    check("w1_wdata", 16'(write_data), 16'h003C);
    expect_resp("w1", 8'h3C, 1'b0);
    check("w1_we_cycles", 16'(we_low_cnt - we0), 16'd1);

    // READ r1: no write strobe anywhere in the command
    we0 = we_low_cnt;
    do_read("rd1", 1'b1, 8'h3C);
    check("rd1_no_write", 16'(we_low_cnt - we0), 16'd0);

    // ADD with wrap-around: FF + 01 -> 00, carry 1, written to r1
    do_write(1'b0, 8'hFF);
    do_write(1'b1, 8'h01);
    we0 = we_low_cnt;
    send(OP_ADD, 1'b1, 8'h77);
    check("add_rr1", 16'(read_register1), 16'd0);
    check("add_rr2", 16'(read_register2), 16'd1);
    check("add_we", 16'(write_enable), 16'd0);
    check("add_wreg", 16'(write_register), 16'd1);
    check("add_wdata", 16'(write_data), 16'h0000);
    expect_resp("add", 8'h00, 1'b1);
    check("add_we_cycles", 16'(we_low_cnt - we0), 16'd1);
    do_read("add_rb", 1'b1, 8'h00);

    // SWAP r0=12, r1=34
    do_write(1'b0, 8'h12);
    do_write(1'b1, 8'h34);
    we0 = we_low_cnt;
    send(OP_SWAP, 1'b0, 8'h00);
    check("sw_exec_we", 16'(write_enable), 16'd0);
    check("sw_exec_wreg", 16'(write_register), 16'd0);
    check("sw_exec_wdata", 16'(write_data), 16'h0034);
    @(negedge clock);
    check("sw_swap2_we", 16'(write_enable), 16'd0);
    check("sw_swap2_wreg", 16'(write_register), 16'd1);
    check("sw_swap2_wdata", 16'(write_data), 16'h0012);
    check("sw_swap2_rsp_valid", 16'(rsp_valid), 16'd0);
    expect_resp("sw", 8'h12, 1'b0);
    check("sw_we_cycles", 16'(we_low_cnt - we0), 16'd2);
    do_read("sw_rb0", 1'b0, 8'h34);
    do_read("sw_rb1", 1'b1, 8'h12);

    // Response backpressure: the held response stays stable and new
    // commands are refused.
    rsp_ready = 1'b0;
    we0 = we_low_cnt;
    do_read("bp", 1'b0, 8'h34);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = OP_WRITE;
      cmd_reg   = 1'b1;
      cmd_data  = 8'hEE;
      @(negedge clock);
      check("bp_hold_valid", 16'(rsp_valid), 16'd1);
      check("bp_hold_data", 16'(rsp_data), 16'h0034);
      check("bp_hold_cmd_ready", 16'(cmd_ready), 16'd0);
    end
    cmd_valid = 1'b0;
    check("bp_no_write", 16'(we_low_cnt - we0), 16'd0);
    check("bp_rf1_kept", 16'(rf[1]), 16'h0012);
    hs0 = hs_cnt;
    rsp_ready = 1'b1;
    @(negedge clock);
    check("bp_one_handshake", 16'(hs_cnt - hs0), 16'd1);
    check("bp_rel_rsp_valid", 16'(rsp_valid), 16'd0);
    check("bp_rel_cmd_ready", 16'(cmd_ready), 16'd1);
    @(negedge clock);
    check("bp_no_extra_hs", 16'(hs_cnt - hs0), 16'd1);

    // Reset during SWAP2: the write strobe drops at once and the response
    // is never produced.
    do_write(1'b0, 8'h55);
    do_write(1'b1, 8'hAA);
    send(OP_SWAP, 1'b0, 8'h00);
    @(negedge clock);
    check("rs_swap2_we", 16'(write_enable), 16'd0);
    rv0 = rv_cnt;
    #1 reset = 1'b1;
    #1;
    check("rs_we_async", 16'(write_enable), 16'd1);
    check("rs_rsp_valid", 16'(rsp_valid), 16'd0);
    check("rs_cmd_ready", 16'(cmd_ready), 16'd1);
    check("rs_busy", 16'(busy), 16'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("rs_no_response", 16'(rv_cnt - rv0), 16'd0);
    check("rs_idle_busy", 16'(busy), 16'd0);
    check("rs_r0_updated", 16'(rf[0]), 16'h00AA);
    check("rs_r1_stale", 16'(rf[1]), 16'h00AA);

    // Normal operation after reset
    do_read("post_rst", 1'b0, 8'hAA);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
